// File: rtl/branch_resolver.sv
// Requester side of a 2-bit branch predictor: issues prediction requests, queues the
// returned predictions in fetch order, trains the predictor on resolution and flags mispredicts.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_valid,
    output logic                     br_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     request,
    input  logic                     prediction,
    output logic                     result,
    output logic                     taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         resolved_cnt,
    output logic [CNT_W-1:0]         mispred_cnt
);
    // Handshakes: a branch is accepted on a cycle where br_valid && br_ready; a resolve is
    // accepted on a cycle where resolve_valid && resolve_ready. Both take effect at that clk edge.
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DEPTH-1:0] pred_q, pred_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] resolved_q, resolved_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic res_acc;
    logic mis_now;
    logic push;

    assign occupancy     = count_q + OW'(inflight_q);
    assign resolve_ready = (count_q != '0);
    assign res_acc       = resolve_valid && resolve_ready && !rst;
    assign mis_now       = res_acc && (pred_q[rd_ptr_q] != resolve_taken);
    assign br_ready      = (occupancy < OW'(DEPTH)) && !mis_now;
    assign request       = br_valid && br_ready && !rst;
    assign result        = res_acc;
    assign taken         = resolve_taken;
    assign mispredict    = mispredict_q;
    assign resolved_cnt  = resolved_q;
    assign mispred_cnt   = mispred_q;

    // The prediction arriving this cycle belongs to last cycle's request; a flush drops it.
    assign push = inflight_q && !mis_now;

    always_comb begin
        pred_d       = pred_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        inflight_d   = request;
        mispredict_d = mis_now;
        resolved_d   = resolved_q;
        mispred_d    = mispred_q;

        if (res_acc && (resolved_q != '1)) begin
            resolved_d = resolved_q + CNT_W'(1);
        end
        if (mis_now && (mispred_q != '1)) begin
            mispred_d = mispred_q + CNT_W'(1);
        end

        if (mis_now) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (push) begin
                pred_d[wr_ptr_q] = prediction;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (res_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + OW'(push) - OW'(res_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            mispredict_q <= 1'b0;
            resolved_q   <= '0;
            mispred_q    <= '0;
        end else begin
            pred_q       <= pred_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            mispredict_q <= mispredict_d;
            resolved_q   <= resolved_d;
            mispred_q    <= mispred_d;
        end
    end

endmodule
